nonce_dispatch_ctrl: RTL
========================

// Module: nonce_dispatch_ctrl
// PURPOSE
//  Sequences the nonce search for the miner.
//  - Splits the CSR-programmed range [nonce_start, nonce_end] into chunks of 2**CHUNK_LOG2 nonces.
//  - Hands chunks round-robin to NUM_CORES hash cores.
//  - Broadcasts abort on the first hit, then reports complete/found/found_nonce back to the CSR slave.
//  - Sits between the CSR slave registers and the hash core array.
// PARAMETERS
//  NUM_CORES   4   number of hash cores served
//  NONCE_WIDTH 32  nonce width in bits
//  CHUNK_LOG2  16  log2 of nonces per chunk; 1 <= CHUNK_LOG2 <= NONCE_WIDTH
// PORTS
//  clk          in   1                      single clock, all logic on posedge
//  reset        in   1                      synchronous, active-high
//  start        in   1                      1-cycle pulse from CSR: begin search
//  abort        in   1                      1-cycle pulse from CSR: cancel search
//  nonce_start  in   NONCE_WIDTH            first nonce (inclusive); sampled on start
//  nonce_end    in   NONCE_WIDTH            last nonce (inclusive); sampled on start
//  core_start   out  NUM_CORES              per-core 1-cycle issue pulse
//  core_base    out  NUM_CORES*NONCE_WIDTH  chunk base for core i; valid with core_start[i], held after
//  core_len     out  NUM_CORES*(CHUNK_LOG2+1)  chunk length for core i (1..2**CHUNK_LOG2)
//  core_abort   out  1                      1-cycle broadcast abort pulse
//  core_done    in   NUM_CORES              core i finished its chunk, no hit (pulse)
//  core_found   in   NUM_CORES              core i found a hit (pulse)
//  core_nonce   in   NUM_CORES*NONCE_WIDTH  winning nonce of core i; valid with core_found[i]
//  busy         out  1                      high in DISPATCH or DRAIN
//  complete     out  1                      search finished; held until next start or reset
//  found        out  1                      hit found; held until next start or reset
//  found_nonce  out  NONCE_WIDTH            winning nonce; held until next start or reset
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, rr_ptr=0, core_busy=0, next_base=0.
//  Tracking:
//  - core_busy[i] sets on core_start[i].
//  - core_busy[i] clears on core_done[i], core_found[i] or core_abort.
//  - next_base is NONCE_WIDTH+1 bits, so nonce_end=all-ones does not wrap.
//  States:
//  - IDLE / DONE + start:
//    - Latch the range and clear complete/found/found_nonce.
//    - If nonce_end < nonce_start: go DONE with complete=1, found=0, no issue.
//    - Otherwise: next_base=nonce_start, go DISPATCH.
//  - DISPATCH:
//    - Issue at most one chunk per cycle, to the first non-busy core at or after rr_ptr (wrapping).
//    - core_start[i], core_base[i] and core_len[i] are registered and visible the cycle after the decision.
//    - core_len = min(2**CHUNK_LOG2, nonce_end - next_base + 1).
//    - On issue: next_base += core_len; rr_ptr = i+1 mod NUM_CORES.
//    - When next_base > nonce_end, go DRAIN.
//  - DRAIN:
//    - No issue.
//    - When all core_busy are 0, go DONE with complete=1.
//  - Any core_found in DISPATCH or DRAIN:
//    - found=1; found_nonce = core_nonce of the lowest-index asserting core.
//    - core_abort pulses next cycle; go DONE with complete=1 in that same cycle.
//  - abort in DISPATCH or DRAIN:
//    - core_abort pulses; go IDLE with complete=0 and found=0.
//  Latency:
//  - start sampled at edge t gives DISPATCH at t+1.
//  - The first core_start is high in the cycle after edge t+2.
//  - Total latency = 2 cycles.
//  Simultaneous events (priority: reset > abort > found > done > issue):
//  - core_found and core_done on the same or different cores in one cycle: found wins.
//  - A core freed by core_done at edge t is eligible for issue at edge t+1; never in the same cycle.
//  - start while busy=1 is ignored; abort in IDLE or DONE is ignored (no core_abort).
//  - reset mid-search: everything returns to reset values next edge; no core_abort pulse.
// TESTING
//  1. NUM_CORES=4, CHUNK_LOG2=4, range 0..63, all cores pulse done 5 cycles after start
//     -> bases 0,16,32,48 to cores 0..3 on consecutive cycles, each len 16;
//     -> complete=1, found=0 once all are done.
//  2. Range 0..39, CHUNK_LOG2=4 -> three chunks: len 16,16,8 at bases 0,16,32; no 4th issue.
//  3. Cores 1 and 2 pulse core_found in the same cycle with nonces 0x25 and 0x31
//     -> found_nonce=0x25, core_abort one pulse, complete=1.
//  4. nonce_start=0xFFFFFFF0, nonce_end=0xFFFFFFFF -> single chunk len 16 at 0xFFFFFFF0;
//     DRAIN entered; no wrap, no second issue.
//  5. abort 3 cycles after start -> core_abort pulse, state IDLE, complete=0;
//     a fresh start then restarts the issue sequence at core 0.
//  6. nonce_end < nonce_start -> complete=1 two cycles after start; core_start never asserted.

Source files
------------

// File: rtl/nonce_dispatch_ctrl.sv
// Nonce search sequencer: slices [nonce_start, nonce_end] into fixed-size chunks,
// deals them round-robin to the hash cores, and collects done/hit status.
module nonce_dispatch_ctrl #(
    parameter int NUM_CORES   = 4,
    parameter int NONCE_WIDTH = 32,
    parameter int CHUNK_LOG2  = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   start_i,
    input  logic                                   abort_i,
    input  logic [NONCE_WIDTH-1:0]                 nonce_start_i,
    input  logic [NONCE_WIDTH-1:0]                 nonce_end_i,
    output logic [NUM_CORES-1:0]                   core_start_o,
    output logic [NUM_CORES-1:0][NONCE_WIDTH-1:0]  core_base_o,
    output logic [NUM_CORES-1:0][CHUNK_LOG2:0]     core_len_o,
    output logic                                   core_abort_o,
    input  logic [NUM_CORES-1:0]                   core_done_i,
    input  logic [NUM_CORES-1:0]                   core_found_i,
    input  logic [NUM_CORES-1:0][NONCE_WIDTH-1:0]  core_nonce_i,
    output logic                                   busy_o,
    output logic                                   complete_o,
    output logic                                   found_o,
    output logic [NONCE_WIDTH-1:0]                 found_nonce_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NONCE_WIDTH:0] CHUNK = {{NONCE_WIDTH{1'b0}}, 1'b1} << CHUNK_LOG2;

    logic [1:0]                              state_q, state_d;
    logic                                    start_q, start_d;
    logic [NONCE_WIDTH-1:0]                  lo_q, lo_d, hi_q, hi_d;
    logic [NONCE_WIDTH:0]                    next_base_q, next_base_d;
    logic [PTR_W-1:0]                        rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0]                    core_busy_q, core_busy_d;
    logic [NUM_CORES-1:0]                    core_start_q, core_start_d;
    logic [NUM_CORES-1:0][NONCE_WIDTH-1:0]   core_base_q, core_base_d;
    logic [NUM_CORES-1:0][CHUNK_LOG2:0]      core_len_q, core_len_d;
    logic                                    core_abort_q, core_abort_d;
    logic                                    complete_q, complete_d;
    logic                                    found_q, found_d;
    logic [NONCE_WIDTH-1:0]                  found_nonce_q, found_nonce_d;

    logic                                    pick_vld;
    logic [PTR_W-1:0]                        pick_idx;
    logic [NONCE_WIDTH-1:0]                  win_nonce;
    logic [NONCE_WIDTH:0]                    remain, issue_len;
    int                                      idx;

    assign busy_o = (state_q == S_DISPATCH) || (state_q == S_DRAIN);

    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        lo_d          = lo_q;
        hi_d          = hi_q;
        next_base_d   = next_base_q;
        rr_ptr_d      = rr_ptr_q;
        core_busy_d   = core_busy_q & ~(core_done_i | core_found_i);
        core_start_d  = '0;
        core_base_d   = core_base_q;
        core_len_d    = core_len_q;
        core_abort_d  = 1'b0;
        complete_d    = complete_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;

        // Lowest-index hit wins, so scan from the top and let later hits overwrite.
        win_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (core_found_i[i]) win_nonce = core_nonce_i[i];

        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (!pick_vld && !core_busy_q[idx]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'(idx);
            end
        end

        // hi+1 fits in NONCE_WIDTH+1 bits, so the last chunk length never wraps.
        remain    = {1'b0, hi_q} + (NONCE_WIDTH + 1)'(1) - next_base_q;
        issue_len = (remain < CHUNK) ? remain : CHUNK;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_q) begin
                    if (hi_q < lo_q) begin
                        state_d    = S_DONE;
                        complete_d = 1'b1;
                    end else begin
                        state_d     = S_DISPATCH;
                        next_base_d = {1'b0, lo_q};
                        rr_ptr_d    = '0;
                    end
                end else if (start_i) begin
                    start_d       = 1'b1;
                    lo_d          = nonce_start_i;
                    hi_d          = nonce_end_i;
                    complete_d    = 1'b0;
                    found_d       = 1'b0;
                    found_nonce_d = '0;
                end
            end
            default: begin
                if (abort_i) begin
                    core_abort_d = 1'b1;
                    core_busy_d  = '0;
                    state_d      = S_IDLE;
                    complete_d   = 1'b0;
                    found_d      = 1'b0;
                end else if (|core_found_i) begin
                    core_abort_d  = 1'b1;
                    core_busy_d   = '0;
                    state_d       = S_DONE;
                    complete_d    = 1'b1;
                    found_d       = 1'b1;
                    found_nonce_d = win_nonce;
                end else if (state_q == S_DISPATCH) begin
                    if (pick_vld) begin
                        core_start_d[pick_idx] = 1'b1;
                        core_base_d[pick_idx]  = next_base_q[NONCE_WIDTH-1:0];
                        core_len_d[pick_idx]   = issue_len[CHUNK_LOG2:0];
                        core_busy_d[pick_idx]  = 1'b1;
                        next_base_d            = next_base_q + issue_len;
                        rr_ptr_d               = PTR_W'((int'(pick_idx) + 1) % NUM_CORES);
                        if (next_base_d > {1'b0, hi_q}) state_d = S_DRAIN;
                    end
                end else if (core_busy_q == '0) begin
                    state_d    = S_DONE;
                    complete_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            lo_q          <= '0;
            hi_q          <= '0;
            next_base_q   <= '0;
            rr_ptr_q      <= '0;
            core_busy_q   <= '0;
            core_start_q  <= '0;
            core_base_q   <= '0;
            core_len_q    <= '0;
            core_abort_q  <= 1'b0;
            complete_q    <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            next_base_q   <= next_base_d;
            rr_ptr_q      <= rr_ptr_d;
            core_busy_q   <= core_busy_d;
            core_start_q  <= core_start_d;
            core_base_q   <= core_base_d;
            core_len_q    <= core_len_d;
            core_abort_q  <= core_abort_d;
            complete_q    <= complete_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
        end
    end

    assign core_start_o  = core_start_q;
    assign core_base_o   = core_base_q;
    assign core_len_o    = core_len_q;
    assign core_abort_o  = core_abort_q;
    assign complete_o    = complete_q;
    assign found_o       = found_q;
    assign found_nonce_o = found_nonce_q;

endmodule
